exmem_pipe_stage: RTL

Parametrised, flow-controlled successor to the fixed EX/MEM pipeline register. It carries the EX-stage bundle into MEM behind a valid/ready handshake, adds a one-entry skid register so `in_ready` is fully registered, and supports stall and flush. It turns control bits into bubbles when empty and counts back-pressure cycles for performance debug. It sits between the ALU/execute stage and the data-memory stage.

---
 rtl/exmem_pkg.sv | 31 +++
 rtl/exmem_slot.sv | 54 +++++
 rtl/exmem_pipe_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/exmem_pkg.sv
// Shared defaults, control-bit map and bundle layout for the EX/MEM pipeline stage.
package exmem_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_RA_W   = 4;
   localparam int DEF_FN_W   = 4;
   localparam int DEF_OP_W   = 4;
   localparam int DEF_CTRL_W = 5;
   localparam int DEF_CNT_W  = 16;

   localparam int CTRL_REGWRITE  = 0;
   localparam int CTRL_R0WRITE   = 1;
   localparam int CTRL_MEMREAD   = 2;
   localparam int CTRL_MEMWRITE  = 3;
   localparam int CTRL_MEMSOURCE = 4;

   typedef struct packed {
      logic [DEF_CTRL_W-1:0] ctrl;
      logic [DEF_RA_W-1:0]   ra;
      logic [DEF_FN_W-1:0]   fn;
      logic [DEF_OP_W-1:0]   op;
      logic [DEF_DATA_W-1:0] alu;
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_DATA_W-1:0] r0d;
   } exmem_bundle_t;

   function automatic logic ctrl_touches_mem(input logic [DEF_CTRL_W-1:0] ctrl);
      return ctrl[CTRL_MEMREAD] | ctrl[CTRL_MEMWRITE];
   endfunction

endpackage

// File: rtl/exmem_slot.sv
// One valid+payload register; invalidating turns the slot into a bubble (ctrl cleared, data kept).
module exmem_slot
   import exmem_pkg::*;
#(
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int PAY_W  = DEF_RA_W + DEF_FN_W + DEF_OP_W + 3 * DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              inval_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [PAY_W-1:0]  pay_i,
   output logic              valid_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [PAY_W-1:0]  pay_o
);

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [PAY_W-1:0]  pay_q, pay_d;

   // Invalidate wins over load so a flush can never be undone by a same-cycle load.
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      pay_d   = pay_q;
      if (inval_i) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (load_i) begin
         valid_d = 1'b1;
         ctrl_d  = ctrl_i;
         pay_d   = pay_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         pay_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         pay_q   <= pay_d;
      end
   end

   assign valid_o = valid_q;
   assign ctrl_o  = ctrl_q;
   assign pay_o   = pay_q;

endmodule

// File: rtl/exmem_pipe_stage.sv
// Flow-controlled EX/MEM pipeline register: main slot M drives MEM, skid slot S keeps in_ready registered.
module exmem_pipe_stage
   import exmem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int RA_W   = DEF_RA_W,
   parameter int FN_W   = DEF_FN_W,
   parameter int OP_W   = DEF_OP_W,
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [RA_W-1:0]   in_ra,
   input  logic [FN_W-1:0]   in_fn,
   input  logic [OP_W-1:0]   in_op,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] in_r0d,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [RA_W-1:0]   out_ra,
   output logic [FN_W-1:0]   out_fn,
   output logic [OP_W-1:0]   out_op,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_data,
   output logic [DATA_W-1:0] out_r0d,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int PAY_W = RA_W + FN_W + OP_W + 3 * DATA_W;

   logic              m_valid, s_valid;
   logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_in;
   logic [PAY_W-1:0]  m_pay, s_pay, m_pay_in, in_pay;
   logic              m_load, m_inval, s_load, s_inval, m_from_s;
   logic              accept, rel, m_free;
   logic              in_ready_q, in_ready_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign in_pay = {in_ra, in_fn, in_op, in_alu, in_data, in_r0d};
   assign accept = in_valid && in_ready_q && !flush;
   assign rel    = m_valid && out_ready;
   assign m_free = !m_valid || rel;

   // S is only written while M is blocked, and in_ready is low whenever S holds a beat,
   // so M refilling from S never coincides with an accepted input.
   always_comb begin
      m_load     = 1'b0;
      m_inval    = 1'b0;
      s_load     = 1'b0;
      s_inval    = 1'b0;
      m_from_s   = 1'b0;
      in_ready_d = 1'b1;
      if (flush) begin
         m_inval    = 1'b1;
         s_inval    = 1'b1;
         in_ready_d = 1'b1;
      end else begin
         if (m_free) begin
            if (s_valid) begin
               m_load   = 1'b1;
               m_from_s = 1'b1;
               s_inval  = 1'b1;
            end else if (accept) begin
               m_load = 1'b1;
            end else begin
               m_inval = 1'b1;
            end
         end else if (accept) begin
            s_load = 1'b1;
         end
         in_ready_d = !((s_valid && !s_inval) || s_load);
      end
   end

   assign m_ctrl_in = m_from_s ? s_ctrl : in_ctrl;
   assign m_pay_in  = m_from_s ? s_pay  : in_pay;

   exmem_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_slot_m (
      .clk     (clk),
      .reset   (reset),
      .load_i  (m_load),
      .inval_i (m_inval),
      .ctrl_i  (m_ctrl_in),
      .pay_i   (m_pay_in),
      .valid_o (m_valid),
      .ctrl_o  (m_ctrl),
      .pay_o   (m_pay)
   );

   exmem_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_slot_s (
      .clk     (clk),
      .reset   (reset),
      .load_i  (s_load),
      .inval_i (s_inval),
      .ctrl_i  (in_ctrl),
      .pay_i   (in_pay),
      .valid_o (s_valid),
      .ctrl_o  (s_ctrl),
      .pay_o   (s_pay)
   );

   always_comb begin
      cnt_d = cnt_q;
      if (m_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_ready_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         in_ready_q <= in_ready_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = m_valid;
   assign out_ctrl  = m_ctrl;
   assign {out_ra, out_fn, out_op, out_alu, out_data, out_r0d} = m_pay;
   assign stall_cnt = cnt_q;

endmodule
